microsoc_bus_arbiter: RTL and testbench
=======================================

// Module: microsoc_bus_arbiter
// PURPOSE
//   Parametrised N-master round-robin arbiter for the ibex req/gnt/rvalid memory protocol.
//   Merges ibex instr/data ports (plus future DMA/debug masters) onto one slave port (bootrom/RAM/MMIO).
//   Tracks up to RESP_DEPTH granted-but-unanswered transactions and returns each in-order response
//   to the master that issued it. Supersedes the single-master instr-only hookup in microsoc_top.
// PARAMETERS
//   NUM_MASTERS  2   number of master ports, >=2
//   ADDR_WIDTH   32  address width
//   DATA_WIDTH   32  data width, multiple of 8; BE_WIDTH = DATA_WIDTH/8
//   RESP_DEPTH   2   max outstanding granted transactions (route-FIFO depth), >=1
// PORTS
//   clk          in   1                      clock, all state on rising edge
//   rst          in   1                      asynchronous active-high reset
//   m_req_i      in   NUM_MASTERS            per-master request
//   m_gnt_o      out  NUM_MASTERS            per-master grant
//   m_rvalid_o   out  NUM_MASTERS            per-master response valid
//   m_we_i       in   NUM_MASTERS            per-master write enable
//   m_addr_i     in   NUM_MASTERS*ADDR_WIDTH master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   m_be_i       in   NUM_MASTERS*BE_WIDTH   byte enables, same packing
//   m_wdata_i    in   NUM_MASTERS*DATA_WIDTH write data, same packing
//   m_rdata_o    out  DATA_WIDTH             read data, common to all masters
//   m_err_o      out  NUM_MASTERS            per-master error, valid with m_rvalid_o
//   s_req_o      out  1                      slave request
//   s_gnt_i      in   1                      slave grant
//   s_rvalid_i   in   1                      slave response valid
//   s_we_o/s_addr_o/s_be_o/s_wdata_o  out    1/ADDR_WIDTH/BE_WIDTH/DATA_WIDTH, selected master's fields
//   s_rdata_i    in   DATA_WIDTH             slave read data
//   s_err_i      in   1                      slave error
//   outstanding_o out $clog2(RESP_DEPTH+1)   current route-FIFO occupancy
//   proto_err_o  out  1                      sticky: s_rvalid_i seen with no outstanding transaction
// BEHAVIOUR
//   Reset (async, rst=1): rr pointer=0, lock cleared, route FIFO empty, proto_err_o=0.
//     Outputs while in reset: s_req_o=0, m_gnt_o=0, m_rvalid_o=0, m_err_o=0, outstanding_o=0.
//     Outstanding transactions in flight at reset are discarded; slave must be reset with the arbiter.
//   Arbitration: combinational, zero latency. Winner = first requesting master at or after rr pointer,
//     wrapping NUM_MASTERS-1 -> 0. s_req_o = |m_req_i & !fifo_full. Slave fields mux from winner.
//   Lock: if s_req_o=1 and s_gnt_i=0 at a clock edge, register winner as locked. While locked,
//     selection is forced to the locked master regardless of other requests or pointer.
//     Lock clears on the cycle s_gnt_i=1. Masters must hold req and fields stable until gnt.
//   Grant: m_gnt_o[k] = s_req_o & s_gnt_i & (sel==k); at most one bit set per cycle.
//     On grant: push k into route FIFO; rr pointer <= (k+1) mod NUM_MASTERS.
//   Response: s_rvalid_i=1 with FIFO non-empty -> m_rvalid_o[head]=1, m_err_o[head]=s_err_i,
//     same cycle (combinational); pop FIFO head. m_rdata_o = s_rdata_i always.
//   Full: FIFO holds RESP_DEPTH entries -> s_req_o=0 (no bypass for same-cycle pop); requests resume
//     the cycle after a pop. A lock never exists while full (lock only forms with s_req_o=1).
//   Push and pop in same cycle: allowed when not full; occupancy unchanged.
//   Empty + s_rvalid_i=1: no m_rvalid_o asserted, response dropped, proto_err_o set until reset.
//   Occupancy arithmetic: count width $clog2(RESP_DEPTH+1); never exceeds RESP_DEPTH or underflows.
//   Responses are strictly in order; slave must return them in grant order.
// TESTING
//   Single master 0 read, s_gnt_i same cycle, rvalid 2 cycles later rdata=32'hDEADBEEF -> m_gnt_o=2'b01,
//     m_rvalid_o=2'b01 with 32'hDEADBEEF, outstanding_o 0->1->0.
//   Both masters request continuously, gnt always 1 -> grants alternate 01,10,01,10 from reset.
//   Master 1 requests, s_gnt_i low 3 cycles, master 0 raises req in cycle 2 -> s_addr_o stays master 1's
//     address, gnt goes to master 1 first, then master 0.
//   RESP_DEPTH=2, grants to m0 then m1, no rvalid -> s_req_o=0, outstanding_o=2; rvalid err=1 ->
//     m_rvalid_o=01, m_err_o=01; next rvalid -> m_rvalid_o=10; s_req_o re-asserts after first pop.
//   s_rvalid_i pulse with FIFO empty -> no m_rvalid_o, proto_err_o=1 held until rst.
//   rst asserted mid-cycle with 2 outstanding -> outputs zero immediately, outstanding_o=0, pointer=0.

Source files
------------

// File: rtl/microsoc_bus_arbiter.sv
// Round-robin N-master arbiter for the ibex req/gnt/rvalid protocol onto a single slave port.
// Grants are recorded in a route FIFO so in-order responses return to the issuing master.
module microsoc_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_MASTERS-1:0]                m_req_i,
    output logic [NUM_MASTERS-1:0]                m_gnt_o,
    output logic [NUM_MASTERS-1:0]                m_rvalid_o,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
    output logic [DATA_WIDTH-1:0]                 m_rdata_o,
    output logic [NUM_MASTERS-1:0]                m_err_o,
    output logic                                  s_req_o,
    input  logic                                  s_gnt_i,
    input  logic                                  s_rvalid_i,
    output logic                                  s_we_o,
    output logic [ADDR_WIDTH-1:0]                 s_addr_o,
    output logic [(DATA_WIDTH/8)-1:0]             s_be_o,
    output logic [DATA_WIDTH-1:0]                 s_wdata_o,
    input  logic [DATA_WIDTH-1:0]                 s_rdata_i,
    input  logic                                  s_err_i,
    output logic [$clog2(RESP_DEPTH+1)-1:0]       outstanding_o,
    output logic                                  proto_err_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(NUM_MASTERS);
    localparam int CNT_W    = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] route_q [RESP_DEPTH];
    logic [IDX_W-1:0] route_d [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             proto_err_q, proto_err_d;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] head;
    logic             full;
    logic             grant;
    logic             pop;

    // First requester at or after the rr pointer, wrapping around.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_MASTERS);
            if (!found && m_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign sel  = lock_vld_q ? lock_idx_q : winner;
    assign full = (count_q == CNT_W'(RESP_DEPTH));
    assign head = route_q[rd_ptr_q];

    // Outputs are gated by rst so they drop the instant reset asserts.
    assign s_req_o = !rst && (|m_req_i) && !full;
    assign grant   = s_req_o && s_gnt_i;
    assign pop     = !rst && s_rvalid_i && (count_q != '0);

    assign s_we_o    = m_we_i[sel];
    assign s_addr_o  = m_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_be_o    = m_be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];
    assign s_wdata_o = m_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

    assign m_rdata_o     = s_rdata_i;
    assign outstanding_o = count_q;
    assign proto_err_o   = proto_err_q;

    always_comb begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
            m_gnt_o[k]    = grant && (sel == IDX_W'(k));
            m_rvalid_o[k] = pop && (head == IDX_W'(k));
            m_err_o[k]    = pop && (head == IDX_W'(k)) && s_err_i;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_vld_d  = lock_vld_q;
        lock_idx_d  = lock_idx_q;
        route_d     = route_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        proto_err_d = proto_err_q | (s_rvalid_i && (count_q == '0));

        if (grant) begin
            rr_ptr_d          = (sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
            lock_vld_d        = 1'b0;
            route_d[wr_ptr_q] = sel;
            wr_ptr_d          = (wr_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end else if (s_req_o) begin
            // Slave stalled: pin the selection until it grants.
            lock_vld_d = 1'b1;
            lock_idx_d = sel;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({grant, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            lock_vld_q  <= 1'b0;
            lock_idx_q  <= '0;
            route_q     <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_vld_q  <= lock_vld_d;
            lock_idx_q  <= lock_idx_d;
            route_q     <= route_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_microsoc_bus_arbiter.sv
// Directed bench for microsoc_bus_arbiter with 2 masters and a 2-deep route FIFO.
module tb_microsoc_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req, m_gnt, m_rvalid, m_we, m_err;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_be;
    logic [31:0] m_rdata;
    logic        s_req, s_gnt, s_rvalid, s_we, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic [1:0]  outstanding;
    logic        proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    microsoc_bus_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
        .m_err_o(m_err), .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
        .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .s_err_i(s_err), .outstanding_o(outstanding),
        .proto_err_o(proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; m_req = 2'b11; m_we = 2'b00; m_be = 8'hFF;
        m_addr = {32'h0000_0200, 32'h0000_0100};
        m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        s_gnt = 1'b1; s_rvalid = 1'b1; s_err = 1'b1; s_rdata = 32'h0;

        // Reset holds every output low even with live inputs.
        sample();
        chk("rst_sreq", s_req, 0);
        chk("rst_gnt", m_gnt, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_err", m_err, 0);
        chk("rst_outst", outstanding, 0);
        chk("rst_proto", proto_err, 0);
        tick();
        m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0;
        rst = 1'b0;

        // Single read from master 0, response two cycles after grant.
        m_req = 2'b01; s_gnt = 1'b1;
        sample();
        chk("t1_gnt", m_gnt, 2'b01);
        chk("t1_addr", s_addr, 32'h100);
        chk("t1_outst0", outstanding, 0);
        tick();
        m_req = 2'b00; s_gnt = 1'b0;
        sample();
        chk("t1_outst1", outstanding, 1);
        chk("t1_norv", m_rvalid, 0);
        tick();
        s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
        sample();
        chk("t1_rvalid", m_rvalid, 2'b01);
        chk("t1_rdata", m_rdata, 32'hDEADBEEF);
        chk("t1_err", m_err, 0);
        tick();
        s_rvalid = 1'b0;
        sample();
        chk("t1_outst_end", outstanding, 0);

        // Continuous requests from both masters alternate, responses follow one cycle behind.
        do_reset();
        m_req = 2'b11; s_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            s_rvalid = (c != 0);
            sample();
            chk($sformatf("t2_gnt%0d", c), m_gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("t2_rv%0d", c), m_rvalid,
                (c == 0) ? 2'b00 : ((c % 2 == 1) ? 2'b01 : 2'b10));
            tick();
        end
        m_req = 2'b00;
        sample();
        chk("t2_rv_last", m_rvalid, 2'b10);
        tick();
        s_rvalid = 1'b0;
        sample();
        chk("t2_outst_end", outstanding, 0);

        // Stalled slave locks master 1 even after master 0 (rr priority) starts requesting.
        do_reset();
        m_req = 2'b10; m_we = 2'b10; s_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) m_req = 2'b11;
            sample();
            chk($sformatf("t3_addr%0d", c), s_addr, 32'h200);
            chk($sformatf("t3_nogt%0d", c), m_gnt, 0);
            tick();
        end
        s_gnt = 1'b1;
        sample();
        chk("t3_gnt_m1", m_gnt, 2'b10);
        chk("t3_we", s_we, 1);
        chk("t3_wdata", s_wdata, 32'hBBBB_0001);
        tick();
        m_req = 2'b01; m_we = 2'b00;
        sample();
        chk("t3_gnt_m0", m_gnt, 2'b01);
        chk("t3_addr_m0", s_addr, 32'h100);

        // Fill the route FIFO, then drain it with an error response first.
        do_reset();
        m_req = 2'b01; s_gnt = 1'b1;
        sample();
        chk("t4_gnt0", m_gnt, 2'b01);
        tick();
        m_req = 2'b10;
        sample();
        chk("t4_gnt1", m_gnt, 2'b10);
        tick();
        m_req = 2'b11;
        sample();
        chk("t4_full_sreq", s_req, 0);
        chk("t4_full_gnt", m_gnt, 0);
        chk("t4_full_outst", outstanding, 2);
        tick();
        s_rvalid = 1'b1; s_err = 1'b1;
        sample();
        chk("t4_rv0", m_rvalid, 2'b01);
        chk("t4_err0", m_err, 2'b01);
        chk("t4_nobypass", s_req, 0);
        tick();
        s_err = 1'b0;
        sample();
        chk("t4_rv1", m_rvalid, 2'b10);
        chk("t4_err1", m_err, 2'b00);
        chk("t4_resume", s_req, 1);
        chk("t4_regnt", m_gnt, 2'b01);
        tick();
        m_req = 2'b00; s_rvalid = 1'b0;
        sample();
        chk("t4_outst_pushpop", outstanding, 1);

        // Response with nothing outstanding is dropped and flagged until reset.
        do_reset();
        s_rvalid = 1'b1;
        sample();
        chk("t5_norv", m_rvalid, 0);
        chk("t5_proto_pre", proto_err, 0);
        tick();
        s_rvalid = 1'b0;
        tick();
        tick();
        sample();
        chk("t5_proto_held", proto_err, 1);

        // Mid-cycle reset with two outstanding and the rr pointer at 1.
        do_reset();
        sample();
        chk("t6_proto_clr", proto_err, 0);
        tick();
        m_req = 2'b10; s_gnt = 1'b1;
        tick();
        m_req = 2'b01;
        tick();
        m_req = 2'b11;
        sample();
        chk("t6_outst2", outstanding, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_outst_rst", outstanding, 0);
        chk("t6_sreq_rst", s_req, 0);
        chk("t6_gnt_rst", m_gnt, 0);
        tick();
        rst = 1'b0;
        sample();
        chk("t6_ptr0", m_gnt, 2'b01);
        tick();
        m_req = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
